// File: rtl/if_fetch_pkg.sv
// Shared constants and encodings for the instruction-fetch stage.
// NOP value, FSM states, next-PC select codes and the default reset PC.
package if_fetch_pkg;

  localparam logic [31:0] NOP_INST         = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [2:0]  PC_STEP          = 3'd4;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_e;

  typedef enum logic [1:0] {
    PC_SEL_HOLD   = 2'd0,
    PC_SEL_INC    = 2'd1,
    PC_SEL_TARGET = 2'd2
  } pc_sel_e;

endpackage

// File: rtl/if_pc_next.sv
// Combinational next-PC selection between hold, sequential and redirect target.
// Kept standalone so a variant that resolves jumps in IF can reuse it.
module if_pc_next
  import if_fetch_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] target,
  input  pc_sel_e           sel,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [ADDR_W-1:0] pc_next
);

  // Sequential increment wraps modulo 2^ADDR_W; target is taken verbatim.
  always_comb begin
    pc_plus4 = pc + ADDR_W'(PC_STEP);
    pc_next  = pc;
    case (sel)
      PC_SEL_HOLD:   pc_next = pc;
      PC_SEL_INC:    pc_next = pc_plus4;
      PC_SEL_TARGET: pc_next = target;
      default:       pc_next = pc;
    endcase
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, talks to a variable-latency imem and
// presents {addr, inst, valid} to IF/ID, honouring stall and redirect.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic              clk_i,
  input  logic              start_i,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] target_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [DATA_W-1:0] imem_data_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] inst_o,
  output logic              valid_o
);

  localparam logic [DATA_W-1:0] NOP_W  = DATA_W'(NOP_INST);
  localparam logic [ADDR_W-1:0] ZERO_A = {ADDR_W{1'b0}};

  fetch_state_e      state_r, state_s;
  pc_sel_e           pc_sel_s;
  logic [ADDR_W-1:0] pc_r, pc_next_s, pc_plus4_s;
  logic [DATA_W-1:0] buf_inst_r, buf_inst_s;
  logic [ADDR_W-1:0] buf_addr_r, buf_addr_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic [DATA_W-1:0] inst_r, inst_s;
  logic              valid_r, valid_s;

  if_pc_next #(
    .ADDR_W (ADDR_W)
  ) u_pc_next (
    .pc       (pc_r),
    .target   (target_i),
    .sel      (pc_sel_s),
    .pc_plus4 (pc_plus4_s),
    .pc_next  (pc_next_s)
  );

  assign imem_req_o  = (state_r == FETCH) & start_i;
  assign imem_addr_o = pc_r;
  assign addr_o      = addr_r;
  assign inst_o      = inst_r;
  assign valid_o     = valid_r;

  // Next-state, next-PC select, hold buffer and output register updates.
  always_comb begin
    state_s    = state_r;
    pc_sel_s   = PC_SEL_HOLD;
    buf_inst_s = buf_inst_r;
    buf_addr_s = buf_addr_r;
    addr_s     = addr_r;
    inst_s     = inst_r;
    valid_s    = valid_r;
    if (redirect_i) begin
      // Redirect wins over stall; any same-cycle ack belongs to the dead path.
      state_s    = FETCH;
      pc_sel_s   = PC_SEL_TARGET;
      buf_inst_s = NOP_W;
      buf_addr_s = ZERO_A;
      inst_s     = NOP_W;
      valid_s    = 1'b0;
    end else begin
      case (state_r)
        FETCH: begin
          if (imem_ack_i) begin
            pc_sel_s = PC_SEL_INC;
            if (stall_i) begin
              state_s    = HOLD;
              buf_inst_s = imem_data_i;
              buf_addr_s = pc_plus4_s;
            end else begin
              inst_s  = imem_data_i;
              addr_s  = pc_plus4_s;
              valid_s = 1'b1;
            end
          end else if (!stall_i) begin
            inst_s  = NOP_W;
            valid_s = 1'b0;
          end else begin
            state_s = FETCH;
          end
        end
        HOLD: begin
          if (!stall_i) begin
            state_s = FETCH;
            inst_s  = buf_inst_r;
            addr_s  = buf_addr_r;
            valid_s = 1'b1;
          end else begin
            state_s = HOLD;
          end
        end
        default: begin
          state_s = FETCH;
        end
      endcase
    end
  end

  // State, PC, buffer and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!start_i) begin
      state_r    <= FETCH;
      pc_r       <= RESET_PC;
      buf_inst_r <= NOP_W;
      buf_addr_r <= ZERO_A;
      addr_r     <= ZERO_A;
      inst_r     <= NOP_W;
      valid_r    <= 1'b0;
    end else begin
      state_r    <= state_s;
      pc_r       <= pc_next_s;
      buf_inst_r <= buf_inst_s;
      buf_addr_r <= buf_addr_s;
      addr_r     <= addr_s;
      inst_r     <= inst_s;
      valid_r    <= valid_s;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Directed self-checking bench for if_fetch; a second instance covers PC wrap.
module tb_if_fetch;

  logic        clk;
  logic        start_i, stall_i, redirect_i, imem_ack_i;
  logic [31:0] target_i, imem_data_i;
  logic        imem_req_o, valid_o;
  logic [31:0] imem_addr_o, addr_o, inst_o;
  logic        w_req, w_valid;
  logic [31:0] w_imem_addr, w_addr, w_inst;
  logic [64:0] exp_out;
  int          checks;
  int          errors;

  if_fetch dut (
    .clk_i       (clk),
    .start_i     (start_i),
    .stall_i     (stall_i),
    .redirect_i  (redirect_i),
    .target_i    (target_i),
    .imem_req_o  (imem_req_o),
    .imem_addr_o (imem_addr_o),
    .imem_ack_i  (imem_ack_i),
    .imem_data_i (imem_data_i),
    .addr_o      (addr_o),
    .inst_o      (inst_o),
    .valid_o     (valid_o)
  );

  if_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk_i       (clk),
    .start_i     (start_i),
    .stall_i     (stall_i),
    .redirect_i  (redirect_i),
    .target_i    (target_i),
    .imem_req_o  (w_req),
    .imem_addr_o (w_imem_addr),
    .imem_ack_i  (imem_ack_i),
    .imem_data_i (imem_data_i),
    .addr_o      (w_addr),
    .inst_o      (w_inst),
    .valid_o     (w_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic drive(input logic st, input logic stl, input logic rd,
                       input logic [31:0] tgt, input logic ak, input logic [31:0] dat);
    start_i = st; stall_i = stl; redirect_i = rd;
    target_i = tgt; imem_ack_i = ak; imem_data_i = dat;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step(); step();
    exp_out = {1'b0, 32'h0, 32'h0};
    checks++;
    if ({valid_o, inst_o, addr_o} !== exp_out) begin
      errors++; $display("FAIL reset_out: got %h want %h", {valid_o, inst_o, addr_o}, exp_out);
    end
    checks++;
    if ({imem_req_o, imem_addr_o} !== {1'b0, 32'h0}) begin
      errors++; $display("FAIL reset_imem: got req=%b addr=%h want req=0 addr=0", imem_req_o, imem_addr_o);
    end
    checks++;
    if ({w_valid, w_inst, w_addr, w_imem_addr} !== {1'b0, 32'h0, 32'h0, 32'hFFFF_FFFC}) begin
      errors++; $display("FAIL reset_wrap_inst: got v=%b i=%h a=%h pc=%h want 0 0 0 fffffffc",
                          w_valid, w_inst, w_addr, w_imem_addr);
    end
  endtask

  task automatic test_stream();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h11);
    checks++;
    if ({imem_req_o, imem_addr_o} !== {1'b1, 32'h0}) begin
      errors++; $display("FAIL stream_req0: got req=%b addr=%h want req=1 addr=0", imem_req_o, imem_addr_o);
    end
    step();
    exp_out = {1'b1, 32'h11, 32'h4};
    checks++;
    if ({valid_o, inst_o, addr_o} !== exp_out) begin
      errors++; $display("FAIL stream_w0: got %h want %h", {valid_o, inst_o, addr_o}, exp_out);
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h22);
    checks++;
    if (imem_addr_o !== 32'h4) begin
      errors++; $display("FAIL stream_addr4: got %h want 4", imem_addr_o);
    end
    step();
    exp_out = {1'b1, 32'h22, 32'h8};
    checks++;
    if ({valid_o, inst_o, addr_o} !== exp_out) begin
      errors++; $display("FAIL stream_w1: got %h want %h", {valid_o, inst_o, addr_o}, exp_out);
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++;
    if (imem_addr_o !== 32'h8) begin
      errors++; $display("FAIL stream_addr8: got %h want 8", imem_addr_o);
    end
  endtask

  task automatic test_stall_ack();
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h33);
    step();
    exp_out = {1'b1, 32'h22, 32'h8};
    checks++;
    if ({valid_o, inst_o, addr_o} !== exp_out) begin
      errors++; $display("FAIL stall_frozen0: got %h want %h", {valid_o, inst_o, addr_o}, exp_out);
    end
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++;
    if (imem_req_o !== 1'b0) begin
      errors++; $display("FAIL stall_req_hold0: got %b want 0", imem_req_o);
    end
    step();
    checks++;
    if ({valid_o, inst_o, addr_o, imem_req_o} !== {exp_out, 1'b0}) begin
      errors++; $display("FAIL stall_frozen1: got %h req=%b want %h req=0", {valid_o, inst_o, addr_o}, imem_req_o, exp_out);
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    exp_out = {1'b1, 32'h33, 32'hC};
    checks++;
    if ({valid_o, inst_o, addr_o} !== exp_out) begin
      errors++; $display("FAIL stall_release: got %h want %h", {valid_o, inst_o, addr_o}, exp_out);
    end
    checks++;
    if ({imem_req_o, imem_addr_o} !== {1'b1, 32'hC}) begin
      errors++; $display("FAIL stall_resume: got req=%b addr=%h want req=1 addr=c", imem_req_o, imem_addr_o);
    end
  endtask

  task automatic test_slow_mem();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      checks++;
      if ({imem_req_o, imem_addr_o} !== {1'b1, 32'hC}) begin
        errors++; $display("FAIL slow_addr_%0d: got req=%b addr=%h want req=1 addr=c", i, imem_req_o, imem_addr_o);
      end
      step();
      exp_out = {1'b0, 32'h0, 32'hC};
      checks++;
      if ({valid_o, inst_o, addr_o} !== exp_out) begin
        errors++; $display("FAIL slow_bubble_%0d: got %h want %h", i, {valid_o, inst_o, addr_o}, exp_out);
      end
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h44);
    step();
    exp_out = {1'b1, 32'h44, 32'h10};
    checks++;
    if ({valid_o, inst_o, addr_o} !== exp_out) begin
      errors++; $display("FAIL slow_word: got %h want %h", {valid_o, inst_o, addr_o}, exp_out);
    end
  endtask

  task automatic test_redirect();
    drive(1'b1, 1'b0, 1'b1, 32'h40, 1'b1, 32'hDEAD_BEEF);
    step();
    exp_out = {1'b0, 32'h0, 32'h10};
    checks++;
    if ({valid_o, inst_o, addr_o} !== exp_out) begin
      errors++; $display("FAIL redir_drop: got %h want %h", {valid_o, inst_o, addr_o}, exp_out);
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h55);
    checks++;
    if ({imem_req_o, imem_addr_o} !== {1'b1, 32'h40}) begin
      errors++; $display("FAIL redir_target: got req=%b addr=%h want req=1 addr=40", imem_req_o, imem_addr_o);
    end
    step();
    exp_out = {1'b1, 32'h55, 32'h44};
    checks++;
    if ({valid_o, inst_o, addr_o} !== exp_out) begin
      errors++; $display("FAIL redir_word: got %h want %h", {valid_o, inst_o, addr_o}, exp_out);
    end
  endtask

  task automatic test_redirect_hold();
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h66);
    step();
    drive(1'b1, 1'b1, 1'b1, 32'h80, 1'b0, 32'h0);
    checks++;
    if (imem_req_o !== 1'b0) begin
      errors++; $display("FAIL rh_in_hold: got req=%b want 0", imem_req_o);
    end
    step();
    exp_out = {1'b0, 32'h0, 32'h44};
    checks++;
    if ({valid_o, inst_o, addr_o} !== exp_out) begin
      errors++; $display("FAIL rh_flush: got %h want %h", {valid_o, inst_o, addr_o}, exp_out);
    end
    checks++;
    if ({imem_req_o, imem_addr_o} !== {1'b1, 32'h80}) begin
      errors++; $display("FAIL rh_fetch: got req=%b addr=%h want req=1 addr=80", imem_req_o, imem_addr_o);
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h77);
    step();
    exp_out = {1'b1, 32'h77, 32'h84};
    checks++;
    if ({valid_o, inst_o, addr_o} !== exp_out) begin
      errors++; $display("FAIL rh_word: got %h want %h", {valid_o, inst_o, addr_o}, exp_out);
    end
  endtask

  task automatic test_reset_midwait();
    drive(1'b1, 1'b0, 1'b1, 32'h20, 1'b0, 32'h0);
    step();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    checks++;
    if ({imem_req_o, imem_addr_o} !== {1'b1, 32'h20}) begin
      errors++; $display("FAIL mw_wait: got req=%b addr=%h want req=1 addr=20", imem_req_o, imem_addr_o);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    exp_out = {1'b0, 32'h0, 32'h0};
    checks++;
    if ({valid_o, inst_o, addr_o} !== exp_out) begin
      errors++; $display("FAIL mw_out: got %h want %h", {valid_o, inst_o, addr_o}, exp_out);
    end
    checks++;
    if ({imem_req_o, imem_addr_o} !== {1'b0, 32'h0}) begin
      errors++; $display("FAIL mw_pc: got req=%b addr=%h want req=0 addr=0", imem_req_o, imem_addr_o);
    end
  endtask

  task automatic test_wrap();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h99);
    checks++;
    if ({w_req, w_imem_addr, imem_req_o, imem_addr_o} !== {1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0}) begin
      errors++; $display("FAIL wrap_restart: got wreq=%b waddr=%h req=%b addr=%h want 1 fffffffc 1 0",
                          w_req, w_imem_addr, imem_req_o, imem_addr_o);
    end
    step();
    exp_out = {1'b1, 32'h99, 32'h0};
    checks++;
    if ({w_valid, w_inst, w_addr} !== exp_out) begin
      errors++; $display("FAIL wrap_out: got %h want %h", {w_valid, w_inst, w_addr}, exp_out);
    end
    checks++;
    if (w_imem_addr !== 32'h0) begin
      errors++; $display("FAIL wrap_pc: got %h want 0", w_imem_addr);
    end
    exp_out = {1'b1, 32'h99, 32'h4};
    checks++;
    if ({valid_o, inst_o, addr_o, imem_addr_o} !== {exp_out, 32'h4}) begin
      errors++; $display("FAIL wrap_main: got %h pc=%h want %h pc=4", {valid_o, inst_o, addr_o}, imem_addr_o, exp_out);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    test_reset();
    test_stream();
    test_stall_ack();
    test_slow_mem();
    test_redirect();
    test_redirect_hold();
    test_reset_midwait();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage sitting directly upstream of the IF/ID pipeline register.
- Owns the PC, issues requests to a variable-latency instruction memory and produces {addr, inst, valid} for IF/ID.
- Honours stall from the hazard unit and PC redirect (branch/jump) from ID.
- Flushes the in-flight slot on redirect.

Parameters:
- ADDR_W, 32, PC / memory address width.
- DATA_W, 32, instruction width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- start_i  in  1  reset; synchronous, active-low (0 = held in reset).
- stall_i  in  1  downstream not accepting; hold outputs.
- redirect_i  in  1  branch/jump taken in ID; load target_i.
- target_i  in  ADDR_W  redirect target PC.
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  ADDR_W  fetch address (= pc).
- imem_ack_i  in  1  imem_data_i valid this cycle.
- imem_data_i  in  DATA_W  instruction word.
- addr_o  out  ADDR_W  PC+4 of presented instruction (to IF/ID addr_i).
- inst_o  out  DATA_W  presented instruction (to IF/ID inst_i); 0 = NOP bubble.
- valid_o  out  1  inst_o is a real instruction.

Behaviour:
- Reset (start_i=0 at edge): pc=RESET_PC, state=FETCH, addr_o=0, inst_o=0, valid_o=0, hold buffer cleared.
- imem_req_o is combinational: (state==FETCH) & start_i. imem_addr_o=pc.
- States: FETCH (request outstanding), HOLD (one fetched word buffered, req=0).
- Priority per edge: reset > redirect_i > stall_i > normal.
- redirect_i=1, regardless of stall or state:
  - pc<=target_i, state<=FETCH, buffer discarded.
  - Same-cycle ack data discarded.
  - Outputs: valid_o<=0, inst_o<=0; addr_o holds.
- FETCH, ack=1, stall=0: inst_o<=imem_data_i, addr_o<=pc+4, valid_o<=1, pc<=pc+4.
- FETCH, ack=1, stall=1: buffer<={data, pc+4}, pc<=pc+4, state<=HOLD; outputs hold.
- FETCH, ack=0, stall=0: bubble, i.e. valid_o<=0, inst_o<=0, addr_o holds.
- FETCH, ack=0, stall=1: outputs hold.
- HOLD, stall=1: everything holds.
- HOLD, stall=0: outputs<=buffer, valid_o<=1, state<=FETCH.
- Memory contract:
  - imem_addr_o is stable while req=1, except on redirect.
  - An address change restarts the memory access.
  - ack only when req=1.
- Latency: with ack in the same cycle as req, one instruction per cycle. Each output appears one edge after its ack.
- Arithmetic: pc+4 is modulo 2^ADDR_W; 32'hFFFF_FFFC wraps to 0 with no error.
- No PC alignment checks; target_i is used verbatim.
- Reset mid-HOLD or mid-wait: buffer and outstanding fetch are dropped, and fetch restarts at RESET_PC on the first edge with start_i=1.

Decomposition:
- Shared package holds:
  - NOP_INST=32'h0.
  - State encoding (FETCH, HOLD).
  - Default RESET_PC constant.
- One sub-module: if_pc_next. Combinational next-PC select {pc, pc+4, target_i} plus the adder, kept separate so a jump-in-IF variant can reuse it.
- FSM, buffer and output registers live in if_fetch.

Test Plan:
1. Reset then streaming:
   - Stimulus: start_i=0 for 2 edges; then 1, ack=1 every cycle, ROM[0]=0x11, ROM[4]=0x22.
   - Required: valid/inst/addr = (1,0x11,4) then (1,0x22,8); imem_addr_o 0,4,8.
2. Slow memory:
   - Stimulus: ack delayed 3 cycles per word.
   - Required: valid_o=0, inst_o=0 for 3 cycles, then one valid word; imem_addr_o stable throughout.
3. Stall with ack:
   - Stimulus: stall_i=1 on the cycle ROM[8]=0x33 acks, held 2 cycles.
   - Required: req=0 during HOLD, outputs frozen. On release: (1,0x33,12), then fetch resumes at 12.
4. Redirect:
   - Stimulus: redirect_i=1, target_i=0x40 in the same cycle as an ack.
   - Required: acked word dropped; next edge valid_o=0, inst_o=0; imem_addr_o=0x40; then (1,ROM[0x40],0x44).
5. Redirect during stall+HOLD:
   - Required: buffer discarded, state FETCH at target, valid_o=0.
6. Reset mid-wait and wrap:
   - Reset mid-wait required: start_i=0 with req outstanding at pc=0x20 gives all outputs 0 and pc=RESET_PC.
   - Wrap required: RESET_PC=0xFFFFFFFC gives addr_o=0 and next imem_addr_o=0.
